// File: rtl/iter_shifter16_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Definitions shared by the iterative shifter and its single-step unit:
//   - mode encodings (3-bit, bit 1 is a don't-care for rotates and left shift)
//   - internal operation enum plus decoder from the raw mode field
//   - FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package shifter_pkg;

  // Canonical encodings. Rotates: mode[2]=1, mode[0] selects direction,
  // mode[1] ignored. Logical left: mode[2]=0, mode[0]=0, mode[1] ignored.
  localparam logic [2:0] MODE_ROL = 3'b100;
  localparam logic [2:0] MODE_ROR = 3'b101;
  localparam logic [2:0] MODE_LSH = 3'b000;
  localparam logic [2:0] MODE_SHR = 3'b001;
  localparam logic [2:0] MODE_SAR = 3'b011;

  typedef enum logic [2:0] {
    OP_ROL = 3'd0,
    OP_ROR = 3'd1,
    OP_LSH = 3'd2,
    OP_SHR = 3'd3,
    OP_SAR = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Collapse the don't-care bit so every one of the eight codes maps to an op.
  function automatic op_e decode_mode(input logic [2:0] m);
    op_e op;
    if (m[2]) begin
      op = m[0] ? OP_ROR : OP_ROL;
    end else if (!m[0]) begin
      op = OP_LSH;
    end else begin
      op = m[1] ? OP_SAR : OP_SHR;
    end
    return op;
  endfunction

endpackage

// File: rtl/iter_shifter16_if.sv
// -----------------------------------------------------------------------------
// iter_shifter16_if
// Request/response bundle for the iterative shifter.
//   request : in_valid, in_ready, data_in[WIDTH], shift[SHW], mode[3]
//   response: out_valid, out_ready, data_out[WIDTH]
//   status  : busy
// Modports: master (requester/consumer side), slave (shifter side).
// -----------------------------------------------------------------------------
interface iter_shifter16_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic [SHW-1:0]   shift;
  logic [2:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             busy;

  modport master (
    output in_valid, data_in, shift, mode, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  in_valid, data_in, shift, mode, out_ready,
    output in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/iter_shifter16_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Combinational one-position shift/rotate of a WIDTH-bit word.
// Ports:
//   data_i [WIDTH] in  : operand
//   mode_i [3]     in  : operation select (shifter_pkg encodings)
//   data_o [WIDTH] out : operand moved by one bit position
// -----------------------------------------------------------------------------
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [2:0]       mode_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (decode_mode(mode_i))
      OP_ROL:  data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
      OP_ROR:  data_o = {data_i[0], data_i[WIDTH-1:1]};
      OP_LSH:  data_o = {data_i[WIDTH-2:0], 1'b0};
      OP_SHR:  data_o = {1'b0, data_i[WIDTH-1:1]};
      OP_SAR:  data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/iter_shifter16.sv
// -----------------------------------------------------------------------------
// iter_shifter16
// Bit-serial shift/rotate engine. A request is captured into one shift
// register and moved one position per clock until the down-counter expires,
// then the result is offered on the response handshake. Results match the
// combinational 16-bit universal shifter for the same (data, shift, mode).
//
// Ports:
//   clk          in  : rising-edge clock
//   rst          in  : asynchronous active-high reset
//   bus (slave)      : in_valid/in_ready/data_in/shift/mode request,
//                      out_valid/out_ready/data_out response, busy status
//
// Build option ITER_SHIFTER16_RADIX4_EN: when defined, two positions are
// applied per cycle while the counter is >= 2 (second shift_step chained
// behind the first); results are unchanged, only latency shrinks.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request, in_ready=1
// SHIFT | stepping the shift register, cnt = positions still to go
// DONE  | result presented with out_valid=1 until out_ready
// -----------------------------------------------------------------------------
module iter_shifter16
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  iter_shifter16_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;

  logic [WIDTH-1:0] step1;

  shift_step #(.WIDTH(WIDTH)) u_step0 (
    .data_i (sreg_q),
    .mode_i (mode_q),
    .data_o (step1)
  );

`ifdef ITER_SHIFTER16_RADIX4_EN
  logic [WIDTH-1:0] step2;

  shift_step #(.WIDTH(WIDTH)) u_step1 (
    .data_i (step1),
    .mode_i (mode_q),
    .data_o (step2)
  );
`endif

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sreg_d  = bus.data_in;
          cnt_d   = bus.shift;
          mode_d  = bus.mode;
          state_d = (bus.shift == '0) ? DONE : SHIFT;
        end
      end

      SHIFT: begin
        // cnt is never zero here: a zero shift goes straight to DONE.
`ifdef ITER_SHIFTER16_RADIX4_EN
        if (cnt_q >= SHW'(2)) begin
          sreg_d = step2;
          cnt_d  = cnt_q - SHW'(2);
        end else begin
          sreg_d = step1;
          cnt_d  = cnt_q - SHW'(1);
        end
        if (cnt_q <= SHW'(2)) begin
          state_d = DONE;
        end
`else
        sreg_d = step1;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = DONE;
        end
`endif
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.data_out  = sreg_q;

endmodule

// File: tb/tb_iter_shifter16.sv
// -----------------------------------------------------------------------------
// tb_iter_shifter16
// Directed self-checking bench for iter_shifter16. Inputs are driven and
// outputs sampled on the falling clock edge. Latency is counted in cycles
// from the cycle in which the request is presented (shift=0 -> 1).
// -----------------------------------------------------------------------------
module tb_iter_shifter16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  iter_shifter16_if #(.WIDTH(16)) bus ();

  iter_shifter16 #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  s;
    logic [2:0]  m;
    logic [15:0] exp;
  } vec_t;

  function automatic int exp_lat(input int s);
`ifdef ITER_SHIFTER16_RADIX4_EN
    return (s + 1) / 2 + 1;
`else
    return s + 1;
`endif
  endfunction

  // Presents one request with out_ready=1 and reports what came back.
  // lat = -1 if no result appeared within the cycle budget.
  task automatic do_req(input logic [15:0] d, input logic [3:0] s,
                        input logic [2:0] m, output logic [15:0] res,
                        output int lat, output bit wide1);
    @(negedge clk);
    bus.data_in   = d;
    bus.shift     = s;
    bus.mode      = m;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin
      lat   = -1;
      res   = 'x;
      wide1 = 1'b0;
    end else begin
      res = bus.data_out;
      @(negedge clk);
      wide1 = !bus.out_valid && bus.in_ready;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
    checks++;
    if (bus.data_out !== 16'h0000) begin
      errors++; $display("FAIL reset_data_out got=%h exp=0000", bus.data_out);
    end
  endtask

  task automatic test_rol_basic();
    logic [15:0] res;
    int lat;
    bit w;
    do_req(16'h8001, 4'd1, 3'b100, res, lat, w);
    checks++;
    if (res !== 16'h0003) begin
      errors++; $display("FAIL rol_basic_data got=%h exp=0003", res);
    end
    checks++;
    if (lat !== exp_lat(1)) begin
      errors++; $display("FAIL rol_basic_latency got=%0d exp=%0d", lat, exp_lat(1));
    end
    checks++;
    if (w !== 1'b1) begin
      errors++; $display("FAIL rol_basic_one_cycle_wide got=%b exp=1", w);
    end
  endtask

  task automatic test_patterns();
    vec_t v[11];
    logic [15:0] res;
    int lat;
    bit w;
    v[0]  = '{16'h8000, 4'd15, 3'b011, 16'hFFFF};  // SAR
    v[1]  = '{16'h8000, 4'd15, 3'b001, 16'h0001};  // SHR
    v[2]  = '{16'h0001, 4'd15, 3'b010, 16'h8000};  // LSH (bit1 don't-care)
    v[3]  = '{16'h0001, 4'd4,  3'b111, 16'h1000};  // ROR (bit1 don't-care)
    v[4]  = '{16'h8001, 4'd3,  3'b101, 16'h3000};  // ROR
    v[5]  = '{16'h1234, 4'd8,  3'b110, 16'h3412};  // ROL
    v[6]  = '{16'h4000, 4'd2,  3'b011, 16'h1000};  // SAR, positive
    v[7]  = '{16'hF00F, 4'd4,  3'b001, 16'h0F00};  // SHR
    v[8]  = '{16'hF00F, 4'd4,  3'b000, 16'h00F0};  // LSH
    v[9]  = '{16'h8421, 4'd15, 3'b100, 16'hC210};  // ROL by 15 == ROR by 1
    v[10] = '{16'hB000, 4'd5,  3'b011, 16'hFD80};  // SAR, negative
    for (int i = 0; i < 11; i++) begin
      do_req(v[i].d, v[i].s, v[i].m, res, lat, w);
      checks++;
      if (res !== v[i].exp) begin
        errors++;
        $display("FAIL pattern%0d_data got=%h exp=%h", i, res, v[i].exp);
      end
      checks++;
      if (lat !== exp_lat(int'(v[i].s))) begin
        errors++;
        $display("FAIL pattern%0d_latency got=%0d exp=%0d", i, lat, exp_lat(int'(v[i].s)));
      end
    end
  endtask

  task automatic test_shift_zero();
    logic [2:0] modes[4];
    logic [15:0] res;
    int lat;
    bit w;
    modes[0] = 3'b000; modes[1] = 3'b101; modes[2] = 3'b011; modes[3] = 3'b110;
    for (int i = 0; i < 4; i++) begin
      do_req(16'hA5C3, 4'd0, modes[i], res, lat, w);
      checks++;
      if (res !== 16'hA5C3) begin
        errors++; $display("FAIL shift0_mode%0d_data got=%h exp=a5c3", i, res);
      end
      checks++;
      if (lat !== 1) begin
        errors++; $display("FAIL shift0_mode%0d_latency got=%0d exp=1", i, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [15:0] res;
    int lat;
    bit w;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.data_in   = 16'h00FF;
    bus.shift     = 4'd4;
    bus.mode      = 3'b000;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.out_valid) begin
      errors++; $display("FAIL bp_result_timeout got=no_out_valid exp=out_valid");
    end
    // Stall for five cycles while a competing request is offered.
    bus.data_in  = 16'hFFFF;
    bus.shift    = 4'd0;
    bus.mode     = 3'b100;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.data_out !== 16'h0FF0) begin
        errors++;
        $display("FAIL bp_hold%0d got=valid:%b data:%h exp=valid:1 data:0ff0",
                 i, bus.out_valid, bus.data_out);
      end
      checks++;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_blocked%0d got=in_ready:%b busy:%b exp=in_ready:0 busy:1",
                 i, bus.in_ready, bus.busy);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got=in_ready:%b out_valid:%b exp=in_ready:1 out_valid:0",
               bus.in_ready, bus.out_valid);
    end
    do_req(16'h0F0F, 4'd2, 3'b001, res, lat, w);
    checks++;
    if (res !== 16'h03C3) begin
      errors++; $display("FAIL bp_next_data got=%h exp=03c3", res);
    end
    checks++;
    if (lat !== exp_lat(2)) begin
      errors++; $display("FAIL bp_next_latency got=%0d exp=%0d", lat, exp_lat(2));
    end
  endtask

  task automatic test_reset_mid();
    bit saw_valid;
    logic [15:0] res;
    int lat;
    bit w;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.data_in   = 16'h1234;
    bus.shift     = 4'd10;
    bus.mode      = 3'b100;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_busy_before got=%b exp=1", bus.busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0
        || bus.data_out !== 16'h0000) begin
      errors++;
      $display("FAIL rstmid_values got=busy:%b in_ready:%b out_valid:%b data:%h exp=0/1/0/0000",
               bus.busy, bus.in_ready, bus.out_valid, bus.data_out);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_result got=out_valid_seen exp=none");
    end
    do_req(16'h1234, 4'd4, 3'b100, res, lat, w);
    checks++;
    if (res !== 16'h2341) begin
      errors++; $display("FAIL rstmid_next_data got=%h exp=2341", res);
    end
    checks++;
    if (lat !== exp_lat(4)) begin
      errors++; $display("FAIL rstmid_next_latency got=%0d exp=%0d", lat, exp_lat(4));
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.shift     = '0;
    bus.mode      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_rol_basic();
    test_patterns();
    test_shift_zero();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_shifter16.md
# iter_shifter16

Sequential, bit-serial counterpart of the 16-bit universal shifter: accepts an operand, shift amount and mode through a valid/ready handshake. It performs the rotate/shift one bit position per clock in a single shift register. It returns the result through a second valid/ready handshake. It serves area-constrained paths where a full barrel network is not warranted, and produces bit-identical results to the combinational shifter for the same (data, shift, mode).

## Interface
Parameters:
- WIDTH, 16, operand width; power of two, ≥ 4
- SHW, $clog2(WIDTH), shift-amount width (4 at default)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- data_in  input  WIDTH  operand
- shift  input  SHW  shift amount, 0..WIDTH-1
- mode  input  3  operation select
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- data_out  output  WIDTH  result
- busy  output  1  state ≠ IDLE

## Operation
- Mode encoding, identical to the combinational shifter:
  - 1x0: rotate left
  - 1x1: rotate right
  - 0x0: logical left, zero fill
  - 001: logical right, zero fill
  - 011: arithmetic right, MSB fill
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch data_in into the shift register, shift into the down-counter cnt, and mode into mode_q.
  - Next state is DONE if shift==0, else SHIFT.
- SHIFT:
  - Each cycle, apply a one-position operation per mode_q and decrement cnt.
  - When cnt==1 at the start of the cycle, transition to DONE after that step.
- DONE:
  - out_valid=1, data_out = shift register.
  - Hold until out_ready=1, then return to IDLE.
- Inputs are sampled only at acceptance. Changes to data_in/shift/mode while busy have no effect.
- in_ready=0 in SHIFT and DONE; in_valid is ignored there. There is no same-cycle accept on out handshake.
- data_out is always driven from the shift register; it is meaningful only while out_valid=1.
- Arithmetic: cnt is SHW bits and never underflows. Rotates wrap MSB↔LSB per step.

## Timing
- Reset (async assert, sync release): state=IDLE, shift register=0, cnt=0, mode_q=0, out_valid=0, busy=0, in_ready=1.
- Accept at edge 0 → out_valid high after edge shift+1, i.e. latency = shift+1 cycles (shift=0 → 1 cycle; shift=15 → 16 cycles).
- Back-pressure: out_valid and data_out remain stable for every cycle out_ready=0.
- Result handshake at edge N → in_ready=1 from cycle N+1.
- Reset asserted mid-SHIFT or mid-DONE: immediate return to reset values. The in-flight request is discarded and no out_valid is produced.

## Configuration
- ITER_SHIFTER16_RADIX4_EN:
  - Defined: SHIFT applies two positions per cycle while cnt ≥ 2, one position when cnt==1. Latency = ceil(shift/2)+1 (shift=15 → 9 cycles).
  - Undefined: strictly one position per cycle as above.
- Results are identical in both builds.

## Structure
- Shared package shifter_pkg holds:
  - mode encodings as localparams: MODE_ROL, MODE_ROR, MODE_LSH, MODE_SHR, MODE_SAR, with their don't-care-bit decoding
  - FSM state typedef/encoding: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10
- Natural sub-module: shift_step, combinational single-step unit (data, mode → data shifted by one position). It is instantiated twice under ITER_SHIFTER16_RADIX4_EN.
- Everything else (FSM, counter, register) stays in iter_shifter16.

## Test plan
- ROL 0x8001, shift=1, mode=100, out_ready=1 → data_out=0x0003, out_valid exactly 2 cycles after accept, one cycle wide.
- SAR 0x8000, shift=15, mode=011 → 0xFFFF after 16 cycles (9 with RADIX4_EN). SHR same operand, mode=001 → 0x0001.
- LSH 0x0001, shift=15, mode=010 → 0x8000. ROR 0x0001, shift=4, mode=111 → 0x1000.
- shift=0, any mode, data 0xA5C3 → 0xA5C3, latency 1 cycle.
- out_ready held 0 for 5 cycles in DONE: out_valid/data_out stable, in_ready=0, new in_valid ignored. out_ready=1 → in_ready=1 next cycle, and the next request is processed with correct result.
- rst pulsed mid-SHIFT of shift=10 → outputs at reset values immediately, no out_valid, and a subsequent request completes correctly.
